// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit: operands are evaluated when the input
// handshake accepts them, and results queue in a DEPTH-entry output FIFO.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         y,
  output logic                     zero,
  output logic                     ones,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  op_e             op_sel;
  logic [WIDTH-1:0] res;
  logic            res_err;
  logic            res_zero;
  logic            res_ones;
  logic            push;
  logic            pop;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] y_mem    [DEPTH];
  logic             zero_mem [DEPTH];
  logic             ones_mem [DEPTH];
  logic             err_mem  [DEPTH];

  assign op_sel = op_e'(op);

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (op_sel)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_ILL:  res_err = 1'b1;
      default: res_err = 1'b1;
    endcase
  end

  // Illegal beats store a zero result, so ones must be masked explicitly only
  // for the degenerate case where '1 would equal '0 (never), kept for clarity.
  assign res_zero = (res == '0);
  assign res_ones = (res == '1) & ~res_err;

  // Full blocks pushes regardless of a same-cycle pop.
  assign in_ready  = (level < LVL_FULL) & rst_n;
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      y_mem[wr_ptr]    <= res;
      zero_mem[wr_ptr] <= res_zero;
      ones_mem[wr_ptr] <= res_ones;
      err_mem[wr_ptr]  <= res_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign y    = out_valid ? y_mem[rd_ptr]    : '0;
  assign zero = out_valid ? zero_mem[rd_ptr] : 1'b1;
  assign ones = out_valid ? ones_mem[rd_ptr] : 1'b0;
  assign err  = out_valid ? err_mem[rd_ptr]  : 1'b0;

endmodule
